// File: rtl/door_control_pkg.sv
// Shared elevator door definitions: state encoding and parameter defaults.
package door_control_pkg;

    localparam int unsigned DOOR_STATE_W     = 2;
    localparam int unsigned MOVE_CYCLES_DEF  = 4;
    localparam int unsigned DWELL_CYCLES_DEF = 10;
    localparam int unsigned TIMER_W_DEF      = 8;

    typedef enum logic [DOOR_STATE_W-1:0] {
        DOOR_CLOSED  = 2'd0,
        DOOR_OPENING = 2'd1,
        DOOR_OPEN    = 2'd2,
        DOOR_CLOSING = 2'd3
    } door_state_e;

endpackage

// File: rtl/door_timer.sv
// Loadable down-counter shared by all door states; saturates at zero.
module door_timer
    import door_control_pkg::*;
#(
    parameter int unsigned TIMER_W = TIMER_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/door_control.sv
// Elevator door FSM: open on arrival, dwell, auto/forced close, re-open on hold.
module door_control
    import door_control_pkg::*;
#(
    parameter int unsigned MOVE_CYCLES  = MOVE_CYCLES_DEF,
    parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEF,
    parameter int unsigned TIMER_W      = TIMER_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arrived,
    input  logic                    open_btn,
    input  logic                    close_btn,
    input  logic                    obstruction,
    input  logic                    weight_limit_exceeded,
    output logic [DOOR_STATE_W-1:0] door_state,
    output logic                    door_closed,
    output logic                    depart_ok,
    output logic                    overload_alarm
);

    localparam logic [TIMER_W-1:0] MOVE_LOAD  = TIMER_W'(MOVE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);

    door_state_e        state;
    door_state_e        next_state;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_value;
    logic               tmr_dec;
    logic               tmr_zero;
    logic               hold;

    // Any of these keeps the door open (OPEN) or forces a re-open (CLOSING).
    assign hold = open_btn | obstruction | weight_limit_exceeded;

    door_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    // State register plus registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DOOR_CLOSED;
            door_closed <= 1'b1;
            depart_ok   <= 1'b0;
        end else begin
            state       <= next_state;
            door_closed <= (next_state == DOOR_CLOSED);
            depart_ok   <= (state == DOOR_CLOSING) && (next_state == DOOR_CLOSED);
        end
    end

    // Next-state and timer control.
    always_comb begin
        next_state     = state;
        tmr_load       = 1'b0;
        tmr_load_value = MOVE_LOAD;
        tmr_dec        = 1'b0;
        unique case (state)
            DOOR_CLOSED: begin
                if (arrived || open_btn) begin
                    next_state = DOOR_OPENING;
                    tmr_load   = 1'b1;
                end
            end
            DOOR_OPENING: begin
                if (tmr_zero) begin
                    next_state     = DOOR_OPEN;
                    tmr_load       = 1'b1;
                    tmr_load_value = DWELL_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DOOR_OPEN: begin
                // close_btn during a hold is dropped, not remembered.
                if (hold) begin
                    tmr_load       = 1'b1;
                    tmr_load_value = DWELL_LOAD;
                end else if (tmr_zero || close_btn) begin
                    next_state = DOOR_CLOSING;
                    tmr_load   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DOOR_CLOSING: begin
                // Re-open beats completion when both happen together.
                if (hold) begin
                    next_state = DOOR_OPENING;
                    tmr_load   = 1'b1;
                end else if (tmr_zero) begin
                    next_state = DOOR_CLOSED;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: next_state = DOOR_CLOSED;
        endcase
    end

    assign door_state     = state;
    assign overload_alarm = (state == DOOR_OPEN) && weight_limit_exceeded;

endmodule

// File: tb/tb_door_control.sv
// Scoreboard bench for door_control: per-cycle expectations queued, checked at negedge.
module tb_door_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arrived = 1'b0;
    logic       open_btn = 1'b0;
    logic       close_btn = 1'b0;
    logic       obstruction = 1'b0;
    logic       weight_limit_exceeded = 1'b0;
    logic [1:0] door_state;
    logic       door_closed;
    logic       depart_ok;
    logic       overload_alarm;

    typedef struct {
        logic [1:0] st;
        logic       closed;
        logic       dep;
        logic       ovl;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    door_control #(
        .MOVE_CYCLES  (4),
        .DWELL_CYCLES (10),
        .TIMER_W      (8)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .arrived               (arrived),
        .open_btn              (open_btn),
        .close_btn             (close_btn),
        .obstruction           (obstruction),
        .weight_limit_exceeded (weight_limit_exceeded),
        .door_state            (door_state),
        .door_closed           (door_closed),
        .depart_ok             (depart_ok),
        .overload_alarm        (overload_alarm)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle; compare against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (door_state === e.st && door_closed === e.closed &&
                depart_ok === e.dep && overload_alarm === e.ovl) begin
                passes++;
            end else begin
                $display("FAIL %s: got state=%0d closed=%0b dep=%0b ovl=%0b, want state=%0d closed=%0b dep=%0b ovl=%0b",
                         e.nm, door_state, door_closed, depart_ok, overload_alarm,
                         e.st, e.closed, e.dep, e.ovl);
            end
        end
    end

    // One cycle: drive inputs after the edge and queue the outputs expected in this cycle.
    task automatic step(input logic a, input logic o, input logic c, input logic ob,
                        input logic w, input logic r, input logic [1:0] es,
                        input logic ed, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        arrived               = a;
        open_btn              = o;
        close_btn             = c;
        obstruction           = ob;
        weight_limit_exceeded = w;
        reset                 = r;
        e.st     = es;
        e.closed = (es == 2'd0);
        e.dep    = ed;
        e.ovl    = (es == 2'd2) && w;
        e.nm     = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] es, input string nm);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, es, 1'b0, nm);
    endtask

    // Arrival through a full open/dwell/close sequence ending in one depart pulse.
    task automatic full_cycle(input string nm);
        step(1, 0, 0, 0, 0, 0, 2'd0, 1'b0, {nm, "_arrive"});
        idle(4, 2'd1, {nm, "_opening"});
        idle(10, 2'd2, {nm, "_open"});
        idle(4, 2'd3, {nm, "_closing"});
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b1, {nm, "_depart"});
        idle(2, 2'd0, {nm, "_closed_after"});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b0, "reset_state");
        idle(2, 2'd0, "closed_idle");

        // Basic travel timing.
        full_cycle("basic");

        // Overload holds the door open; dwell restarts on release.
        step(1, 0, 0, 0, 0, 0, 2'd0, 1'b0, "ovl_arrive");
        idle(4, 2'd1, "ovl_opening");
        idle(2, 2'd2, "ovl_open_pre");
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1, 0, 2'd2, 1'b0, "ovl_hold");
        idle(10, 2'd2, "ovl_dwell");
        idle(4, 2'd3, "ovl_closing");
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b1, "ovl_depart");
        idle(1, 2'd0, "ovl_closed");

        // Obstruction in closing cycle 2 forces a full re-open.
        step(1, 0, 0, 0, 0, 0, 2'd0, 1'b0, "obs_arrive");
        idle(4, 2'd1, "obs_opening");
        idle(10, 2'd2, "obs_open");
        idle(1, 2'd3, "obs_closing1");
        step(0, 0, 0, 1, 0, 0, 2'd3, 1'b0, "obs_closing2");
        idle(4, 2'd1, "obs_reopening");
        idle(10, 2'd2, "obs_reopen");
        idle(4, 2'd3, "obs_reclosing");
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b1, "obs_depart");
        idle(1, 2'd0, "obs_closed");

        // close_btn in OPEN cycle 3; re-open on last closing cycle; close_btn ignored under load.
        step(1, 0, 0, 0, 0, 0, 2'd0, 1'b0, "cb_arrive");
        idle(4, 2'd1, "cb_opening");
        step(1, 0, 0, 0, 0, 0, 2'd2, 1'b0, "cb_open1_arrived_ignored");
        idle(1, 2'd2, "cb_open2");
        step(0, 0, 1, 0, 0, 0, 2'd2, 1'b0, "cb_open3_close");
        idle(3, 2'd3, "cb_closing");
        step(0, 1, 0, 0, 0, 0, 2'd3, 1'b0, "cb_closing_zero_reopen");
        idle(4, 2'd1, "cb_reopening");
        idle(2, 2'd2, "cb_open_pre");
        step(0, 0, 1, 0, 1, 0, 2'd2, 1'b0, "cb_close_under_load");
        idle(10, 2'd2, "cb_dwell");
        idle(4, 2'd3, "cb_closing2");
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b1, "cb_depart");
        idle(1, 2'd0, "cb_closed");

        // Reset mid-OPENING, then normal operation.
        step(1, 0, 0, 0, 0, 0, 2'd0, 1'b0, "rst_arrive");
        idle(2, 2'd1, "rst_opening");
        step(0, 0, 0, 0, 0, 1, 2'd1, 1'b0, "rst_assert");
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b0, "rst_closed");
        full_cycle("post_rst");

        // Reset on the final closing cycle suppresses depart_ok.
        step(1, 0, 0, 0, 0, 0, 2'd0, 1'b0, "rstc_arrive");
        idle(4, 2'd1, "rstc_opening");
        idle(10, 2'd2, "rstc_open");
        idle(3, 2'd3, "rstc_closing");
        step(0, 0, 0, 0, 0, 1, 2'd3, 1'b0, "rstc_assert");
        step(0, 0, 0, 0, 0, 0, 2'd0, 1'b0, "rstc_no_depart");
        idle(2, 2'd0, "rstc_closed");

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
